uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one uart_transmitter between NREQ byte-producing requesters.
- Accepts one byte at a time from a requester, latches it, and pulses Tx_WR.
- Tracks Tx_BUSY through one full frame, then reports completion to the owning requester.
- Owns the baud_select configuration of the transmitter; changes are applied only between frames.

---
 rtl/uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter/sequencer sharing one UART transmitter between NREQ
//   byte producers. It latches one byte per grant, pulses Tx_WR, follows
//   Tx_BUSY through the frame, and then pulses done to the owner. It also
//   owns the transmitter baud_select; writes made mid-frame are held until
//   the next return to IDLE.
//
// Optional build macro: UART_TX_ARB_TIMEOUT_EN
//   Adds a WAIT_START watchdog. If Tx_BUSY does not rise within
//   TIMEOUT_CYCLES cycles of the Tx_WR cycle, timeout_err pulses and the
//   arbiter returns to IDLE without a done pulse. Without the macro,
//   timeout_err is tied low.
//
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   req[NREQ]              requests, held with data stable until grant
//   req_data[8*NREQ]       packed bytes, requester i at [8i+7:8i]
//   grant[NREQ]            one-cycle pulse: byte latched
//   done[NREQ]             one-cycle pulse: owner's frame finished
//   cfg_baud, cfg_wr       baud selection write
//   Tx_DATA, Tx_WR, Tx_EN  transmitter data, write strobe and enable
//   baud_select            transmitter baud selection
//   Tx_BUSY                transmitter busy flag
//   arb_busy               high whenever the state is not IDLE
//   timeout_err            one-cycle pulse on watchdog abort
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter logic [2:0]  BAUD_DEFAULT   = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    input  logic [2:0]        cfg_baud,
    input  logic              cfg_wr,
    output logic [7:0]        Tx_DATA,
    output logic              Tx_WR,
    output logic              Tx_EN,
    output logic [2:0]        baud_select,
    input  logic              Tx_BUSY,
    output logic              arb_busy,
    output logic              timeout_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_END} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
    logic [7:0]      data_q, data_d;
    logic            wr_q, wr_d;
    logic            en_q;
    logic [2:0]      baud_q, baud_d, pend_baud_q, pend_baud_d;
    logic            pend_q, pend_d;
    logic            busy_q;
    logic            terr_q, terr_d;
    logic            enter_idle;

    logic [PW-1:0]   sel, cand, next_ptr;
    logic            sel_vld;
    int unsigned     idx;

    // First asserted request scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = idx[PW-1:0];
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

    assign next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = '0;
        done_d      = '0;
        data_d      = data_q;
        wr_d        = 1'b0;
        baud_d      = baud_q;
        pend_d      = pend_q;
        pend_baud_d = pend_baud_q;
        terr_d      = 1'b0;
        enter_idle  = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        // Outside IDLE a write is parked; the last one wins.
        if (cfg_wr) begin
            pend_d      = 1'b1;
            pend_baud_d = cfg_baud;
        end

        unique case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (cfg_wr) baud_d = cfg_baud;
                if (sel_vld) begin
                    data_d       = req_data[{sel, 3'b000} +: 8];
                    owner_d      = sel;
                    grant_d[sel] = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                wr_d    = 1'b1;
                state_d = WAIT_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_START: begin
                if (Tx_BUSY) begin
                    state_d = WAIT_END;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    terr_d     = 1'b1;
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                    enter_idle = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_END: begin
                if (!Tx_BUSY) begin
                    done_d[owner_q] = 1'b1;
                    ptr_d           = next_ptr;
                    state_d         = IDLE;
                    enter_idle      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A write on the very edge that enters IDLE is newer than anything parked.
        if (enter_idle) begin
            if (cfg_wr)      baud_d = cfg_baud;
            else if (pend_q) baud_d = pend_baud_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            en_q        <= 1'b0;
            baud_q      <= BAUD_DEFAULT;
            pend_baud_q <= '0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            en_q        <= 1'b1;
            baud_q      <= baud_d;
            pend_baud_q <= pend_baud_d;
            pend_q      <= pend_d;
            busy_q      <= (state_d != IDLE);
            terr_q      <= terr_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

    assign grant       = grant_q;
    assign done        = done_q;
    assign Tx_DATA     = data_q;
    assign Tx_WR       = wr_q;
    assign Tx_EN       = en_q;
    assign baud_select = baud_q;
    assign arb_busy    = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   grant, done;
    logic [2:0]        cfg_baud = 3'b000;
    logic              cfg_wr = 1'b0;
    logic [7:0]        Tx_DATA;
    logic              Tx_WR, Tx_EN;
    logic [2:0]        baud_select;
    logic              Tx_BUSY;
    logic              arb_busy, timeout_err;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .BAUD_DEFAULT(3'b000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .cfg_baud(cfg_baud), .cfg_wr(cfg_wr),
        .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
        .baud_select(baud_select), .Tx_BUSY(Tx_BUSY),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy rises busy_dly cycles after a Tx_WR, lasts busy_len cycles.
    int busy_dly = 2;
    int busy_len = 20;
    bit xmit_en = 1'b1;
    int busy_fall_cyc = -1;
    initial begin
        Tx_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (xmit_en && Tx_WR === 1'b1) begin
                repeat (busy_dly) @(negedge clk);
                Tx_BUSY = 1'b1;
                repeat (busy_len) @(negedge clk);
                Tx_BUSY = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    // Passive event recorder.
    int g_q[$], g_cyc[$], d_q[$], d_cyc[$], wr_cyc[$], te_cyc[$];
    logic [7:0] wr_data[$];
    logic [2:0] wr_baud[$];
    int bad_oh = 0;

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (grant !== '0) begin
                g_q.push_back(idx_of(grant)); g_cyc.push_back(cyc);
                if ($countones(grant) != 1) bad_oh++;
            end
            if (done !== '0) begin
                d_q.push_back(idx_of(done)); d_cyc.push_back(cyc);
                if ($countones(done) != 1) bad_oh++;
            end
            if (Tx_WR === 1'b1) begin
                wr_data.push_back(Tx_DATA); wr_baud.push_back(baud_select); wr_cyc.push_back(cyc);
            end
            if (timeout_err === 1'b1) te_cyc.push_back(cyc);
        end
    end

    task automatic clr();
        g_q.delete(); g_cyc.delete(); d_q.delete(); d_cyc.delete();
        wr_cyc.delete(); wr_data.delete(); wr_baud.delete(); te_cyc.delete();
    endtask

    // Reference model: requests present together are served from ptr
    // upwards, wrapping, and ptr moves just past each served requester.
    int model_ptr = 0;
    int exp_q[$];
    task automatic model_serve(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] m = mask;
        while (m != '0) begin
            int j = model_ptr;
            while (!m[j]) j = (j + 1) % NREQ;
            exp_q.push_back(j);
            m[j] = 1'b0;
            model_ptr = (j + 1) % NREQ;
        end
    endtask

    logic [NREQ-1:0] hold = '0;

    task automatic run_to(input int want_g, input int want_d, input int budget, input string nm);
        int n = 0;
        while ((g_q.size() < want_g || d_q.size() < want_d) && n < budget) begin
            @(negedge clk); #1; n++;
            for (int i = 0; i < NREQ; i++) if (grant[i] && !hold[i]) req[i] = 1'b0;
        end
        if (g_q.size() < want_g || d_q.size() < want_d) begin
            checks++; errors++;
            $display("FAIL %s wait expired: grants %0d dones %0d, required %0d %0d",
                     nm, g_q.size(), d_q.size(), want_g, want_d);
        end
    endtask

    task automatic wait_busy_low(input string nm);
        int n = 0;
        while (Tx_BUSY && n < 200) begin @(negedge clk); #1; n++; end
        if (Tx_BUSY) begin
            checks++; errors++;
            $display("FAIL %s Tx_BUSY never fell", nm);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1; req = '0; hold = '0; cfg_wr = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        model_ptr = 0;
        exp_q.delete();
        clr();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk); #1;
        checks++;
        if ({grant, done, Tx_DATA, Tx_WR, Tx_EN, baud_select, arb_busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_values got g=%h d=%h data=%h wr=%b en=%b baud=%b busy=%b te=%b required all zero",
                     grant, done, Tx_DATA, Tx_WR, Tx_EN, baud_select, arb_busy, timeout_err);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (Tx_EN !== 1'b1) begin errors++; $display("FAIL tx_en got %b required 1", Tx_EN); end
        clr();
    endtask

    task automatic test_single();
        clr(); exp_q.delete();
        busy_dly = 2; busy_len = 20;
        req_data[7:0] = 8'hA5; req[0] = 1'b1;
        model_serve(4'b0001);
        run_to(1, 1, 100, "single");
        checks++;
        if (g_q.size() != 1 || g_q[0] != exp_q[0]) begin
            errors++; $display("FAIL single_grant got %p required [%0d]", g_q, exp_q[0]);
        end
        checks++;
        if (wr_data.size() != 1 || wr_data[0] !== 8'hA5) begin
            errors++; $display("FAIL single_wr got %p required [a5]", wr_data);
        end
        checks++;
        if (wr_cyc.size() != 1 || g_cyc.size() != 1 || wr_cyc[0] != g_cyc[0] + 1) begin
            errors++; $display("FAIL single_wr_latency got wr %p grant %p required wr one cycle after grant", wr_cyc, g_cyc);
        end
        checks++;
        if (d_q.size() != 1 || d_q[0] != 0 || d_cyc[0] != busy_fall_cyc + 1) begin
            errors++; $display("FAIL single_done got %p at %p required [0] at %0d", d_q, d_cyc, busy_fall_cyc + 1);
        end
        checks++;
        if (arb_busy !== 1'b0) begin errors++; $display("FAIL single_idle arb_busy got %b required 0", arb_busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        busy_dly = 2; busy_len = 6;
        req_data = 32'h44332211; req = 4'hF;
        model_serve(4'hF);
        run_to(4, 4, 300, "simultaneous");
        for (int k = 0; k < 4; k++) begin
            logic [7:0] eb;
            eb = 8'h11 * 8'(exp_q[k] + 1);
            checks++;
            if (g_q.size() <= k || d_q.size() <= k || wr_data.size() <= k ||
                g_q[k] != exp_q[k] || d_q[k] != exp_q[k] || wr_data[k] !== eb) begin
                errors++;
                $display("FAIL simultaneous_%0d got grants %p dones %p data %p required req %0d byte %h",
                         k, g_q, d_q, wr_data, exp_q[k], eb);
            end
        end
    endtask

    task automatic test_fairness();
        int exp_f[3] = '{0, 2, 0};
        do_reset();
        busy_dly = 2; busy_len = 8;
        hold[0] = 1'b1; req[0] = 1'b1; req_data[7:0] = 8'h0F;
        run_to(1, 0, 50, "fairness_first");
        req_data[23:16] = 8'h2F; req[2] = 1'b1;
        run_to(3, 0, 200, "fairness_grants");
        hold[0] = 1'b0; req[0] = 1'b0;
        run_to(3, 3, 200, "fairness_dones");
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (g_q.size() <= k || d_q.size() <= k || g_q[k] != exp_f[k] || d_q[k] != exp_f[k]) begin
                errors++; $display("FAIL fairness_%0d got grants %p dones %p required %0d", k, g_q, d_q, exp_f[k]);
            end
        end
    endtask

    task automatic test_cfg();
        int n = 0, glitch = 0;
        clr();
        busy_dly = 2; busy_len = 10;
        req_data[15:8] = 8'h5A; req[1] = 1'b1;
        run_to(1, 0, 50, "cfg_grant");
        while (!Tx_BUSY && n < 50) begin @(negedge clk); #1; n++; end
        repeat (2) @(negedge clk);
        #1 cfg_baud = 3'b111; cfg_wr = 1'b1;
        @(negedge clk); #1 cfg_wr = 1'b0;
        checks++;
        if (baud_select !== 3'b000) begin errors++; $display("FAIL cfg_deferred got %b required 000", baud_select); end
        n = 0;
        while (d_q.size() < 1 && n < 100) begin
            @(negedge clk); #1; n++;
            if (arb_busy && baud_select !== 3'b000) glitch++;
        end
        checks++;
        if (d_q.size() != 1 || baud_select !== 3'b111) begin
            errors++; $display("FAIL cfg_applied got baud %b dones %0d required 111 after one done", baud_select, d_q.size());
        end
        checks++;
        if (glitch != 0) begin errors++; $display("FAIL cfg_glitch got %0d changes required 0", glitch); end
        cfg_baud = 3'b010; cfg_wr = 1'b1;
        @(negedge clk); #1 cfg_wr = 1'b0;
        checks++;
        if (baud_select !== 3'b010) begin errors++; $display("FAIL cfg_idle got %b required 010", baud_select); end
        cfg_baud = 3'b101; cfg_wr = 1'b1; req_data[31:24] = 8'hC3; req[3] = 1'b1;
        @(negedge clk); #1 cfg_wr = 1'b0;
        checks++;
        if (grant !== 4'b1000 || baud_select !== 3'b101) begin
            errors++; $display("FAIL cfg_with_grant got grant %b baud %b required 1000 101", grant, baud_select);
        end
        run_to(2, 2, 100, "cfg_second");
        checks++;
        if (wr_baud.size() != 2 || wr_baud[0] !== 3'b000 || wr_baud[1] !== 3'b101 || wr_data[1] !== 8'hC3) begin
            errors++; $display("FAIL cfg_frame_baud got %p data %p required [000 101] second byte c3", wr_baud, wr_data);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, dsz;
        do_reset();
        busy_dly = 2; busy_len = 20;
        req_data[23:16] = 8'h77; req[2] = 1'b1;
        run_to(1, 0, 50, "rstmid_grant");
        while (!Tx_BUSY && n < 50) begin @(negedge clk); #1; n++; end
        cfg_baud = 3'b110; cfg_wr = 1'b1;
        @(negedge clk); #1 cfg_wr = 1'b0;
        dsz = d_q.size();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({grant, done, Tx_DATA, Tx_WR, Tx_EN, baud_select, arb_busy, timeout_err} !== '0) begin
            errors++; $display("FAIL rstmid_async got data=%h en=%b baud=%b busy=%b required reset values",
                               Tx_DATA, Tx_EN, baud_select, arb_busy);
        end
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        wait_busy_low("rstmid");
        repeat (2) @(negedge clk); #1;
        checks++;
        if (d_q.size() != dsz || baud_select !== 3'b000) begin
            errors++; $display("FAIL rstmid_abandon got dones %p baud %b required no done, baud 000", d_q, baud_select);
        end
        clr(); exp_q.delete(); model_ptr = 0;
        req_data[15:8] = 8'h01; req_data[31:24] = 8'h03; req = 4'b1010;
        model_serve(4'b1010);
        run_to(2, 2, 200, "rstmid_after");
        checks++;
        if (g_q.size() != 2 || g_q[0] != exp_q[0] || g_q[1] != exp_q[1]) begin
            errors++; $display("FAIL rstmid_order got %p required [%0d %0d]", g_q, exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            logic [NREQ-1:0] mask;
            int base_g, cnt;
            mask = 4'($urandom_range(1, 15));
            busy_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 12);
            req_data = $urandom;
            clr(); exp_q.delete();
            model_serve(mask);
            base_g = 0; cnt = $countones(mask);
            req = mask;
            run_to(cnt, cnt, 100 * cnt, "random");
            for (int k = base_g; k < cnt; k++) begin
                logic [31:0] bytes;
                logic [7:0] eb;
                bytes = req_data;
                eb = bytes[8*exp_q[k] +: 8];
                checks++;
                if (g_q.size() <= k || d_q.size() <= k || wr_data.size() <= k ||
                    g_q[k] != exp_q[k] || d_q[k] != exp_q[k] || wr_data[k] !== eb) begin
                    errors++;
                    $display("FAIL random_r%0d_%0d got grants %p dones %p data %p required req %0d byte %h",
                             r, k, g_q, d_q, wr_data, exp_q[k], eb);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        xmit_en = 1'b0;
        req_data[7:0] = 8'hEE; req[0] = 1'b1;
        run_to(1, 0, 50, "watchdog_grant");
        repeat (40) @(negedge clk); #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        checks++;
        if (wr_cyc.size() != 1 || te_cyc.size() != 1 || te_cyc[0] != wr_cyc[0] + 16) begin
            errors++; $display("FAIL watchdog_pulse got wr %p te %p required te 16 cycles after wr", wr_cyc, te_cyc);
        end
        checks++;
        if (d_q.size() != 0 || arb_busy !== 1'b0) begin
            errors++; $display("FAIL watchdog_abort got dones %p arb_busy %b required none, 0", d_q, arb_busy);
        end
`else
        checks++;
        if (arb_busy !== 1'b1 || te_cyc.size() != 0 || d_q.size() != 0) begin
            errors++; $display("FAIL watchdog_off got arb_busy %b te %p dones %p required 1, none, none",
                               arb_busy, te_cyc, d_q);
        end
`endif
        xmit_en = 1'b1;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_cfg();
        test_reset_mid();
        test_random();
        test_watchdog();
        checks++;
        if (bad_oh != 0) begin errors++; $display("FAIL onehot got %0d multi-hot pulses required 0", bad_oh); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
